// File: rtl/game_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : game_tick_gen
// Description : Programmable-period game update strobe with speed levels,
//               pause, restart and a half-rate blink toggle.
// Revision    : 1.0 - initial release
// ============================================================================
module game_tick_gen #(
    parameter int CNT_W       = 24,
    parameter int BASE_PERIOD = 12500000,
    parameter int STEP        = 1000000,
    parameter int NUM_LEVELS  = 8,
    parameter int LVL_W       = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             restart,
    input  logic             speed_up,
    input  logic             speed_clr,
    output logic             tick,
    output logic             blink,
    output logic [LVL_W-1:0] level,
    output logic             at_max
);

    localparam logic [CNT_W-1:0] c_base    = CNT_W'(BASE_PERIOD);
    localparam logic [CNT_W-1:0] c_step    = CNT_W'(STEP);
    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);
    localparam logic [LVL_W-1:0] c_max_lvl = LVL_W'(NUM_LEVELS - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic             r_blink;
    logic [LVL_W-1:0] r_level;
    logic             r_at_max;

    logic [CNT_W-1:0] w_period;
    logic [CNT_W-1:0] w_term;
    logic             w_wrap;
    logic [LVL_W-1:0] w_level_nxt;

    // Period tracks the registered level, so a level change lands on the next edge.
    assign w_period = c_base - (CNT_W'(r_level) * c_step);
    assign w_term   = w_period - c_one;
    assign w_wrap   = en && (r_cnt >= w_term);

    always_comb begin
        w_level_nxt = r_level;
        if (speed_clr) begin
            w_level_nxt = '0;
        end else if (speed_up && (r_level < c_max_lvl)) begin
            w_level_nxt = r_level + LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_tick  <= 1'b0;
            r_blink <= 1'b0;
        end else if (restart) begin
            r_cnt   <= '0;
            r_tick  <= 1'b0;
        end else if (w_wrap) begin
            r_cnt   <= '0;
            r_tick  <= 1'b1;
            r_blink <= ~r_blink;
        end else if (en) begin
            r_cnt   <= r_cnt + c_one;
            r_tick  <= 1'b0;
        end else begin
            r_tick  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level  <= '0;
            r_at_max <= 1'b0;
        end else begin
            r_level  <= w_level_nxt;
            r_at_max <= (w_level_nxt == c_max_lvl);
        end
    end

    assign tick   = r_tick;
    assign blink  = r_blink;
    assign level  = r_level;
    assign at_max = r_at_max;

endmodule
`default_nettype wire

// File: tb/tb_game_tick_gen.sv
`default_nettype none
// Testbench for game_tick_gen: directed stimulus with a tick scoreboard.
module tb_game_tick_gen;

    logic       clk = 1'b0;
    logic       rst, en, restart, speed_up, speed_clr;
    logic       tick, blink, at_max;
    logic [1:0] level;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic       blink;
        logic [1:0] lvl;
    } exp_t;

    exp_t exp_q[$];

    game_tick_gen #(
        .CNT_W(4), .BASE_PERIOD(10), .STEP(2), .NUM_LEVELS(4), .LVL_W(2)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .restart(restart),
        .speed_up(speed_up), .speed_clr(speed_clr),
        .tick(tick), .blink(blink), .level(level), .at_max(at_max)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_tick(input int c, input logic b, input logic [1:0] l);
        exp_t e;
        e.cyc = c; e.blink = b; e.lvl = l;
        exp_q.push_back(e);
    endtask

    // Monitor: every tick consumes one expected entry; overdue entries are misses.
    always @(negedge clk) begin
        exp_t e;
        if (tick === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_tick", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("tick_cycle", cyc, e.cyc);
                chk("tick_blink", int'(blink), int'(e.blink));
                chk("tick_level", int'(level), int'(e.lvl));
            end
        end
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            chk("missed_tick", cyc, e.cyc);
        end
    end

    initial begin
        int t;
        rst = 1'b1; en = 1'b0; restart = 1'b0; speed_up = 1'b0; speed_clr = 1'b0;
        step(3);
        chk("rst_tick", int'(tick), 0);
        chk("rst_blink", int'(blink), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_at_max", int'(at_max), 0);

        // Free run at level 0
        rst = 1'b0; en = 1'b1; t = cyc;
        expect_tick(t + 10, 1'b1, 2'd0);
        expect_tick(t + 20, 1'b0, 2'd0);
        expect_tick(t + 30, 1'b1, 2'd0);
        step(37);

        // Reset mid-period with cnt at 7
        rst = 1'b1; step(1); rst = 1'b0;
        chk("midrst_tick", int'(tick), 0);
        chk("midrst_blink", int'(blink), 0);
        chk("midrst_level", int'(level), 0);
        expect_tick(cyc + 10, 1'b1, 2'd0);
        step(10);

        // Level ramp with the counter paused at 0
        en = 1'b0; speed_up = 1'b1;
        step(1); chk("lvl1", int'(level), 1); chk("lvl1_max", int'(at_max), 0);
        step(1); chk("lvl2", int'(level), 2); chk("lvl2_max", int'(at_max), 0);
        step(1); chk("lvl3", int'(level), 3); chk("lvl3_max", int'(at_max), 1);
        step(1); chk("lvl_sat", int'(level), 3); chk("lvl_sat_max", int'(at_max), 1);
        speed_up = 1'b0; en = 1'b1; t = cyc;
        expect_tick(t + 4,  1'b0, 2'd3);
        expect_tick(t + 8,  1'b1, 2'd3);
        expect_tick(t + 12, 1'b0, 2'd3);
        step(12);

        // speed_clr back to period 10
        speed_clr = 1'b1; t = cyc;
        expect_tick(t + 10, 1'b1, 2'd0);
        expect_tick(t + 20, 1'b0, 2'd0);
        step(1); speed_clr = 1'b0;
        chk("clr_level", int'(level), 0);
        chk("clr_max", int'(at_max), 0);
        step(19);

        // Pause at cnt=6 for 20 cycles
        step(6); en = 1'b0; step(20); en = 1'b1;
        expect_tick(cyc + 4, 1'b1, 2'd0);
        step(4);

        // speed_up at cnt=8: counter already past the new terminal
        step(8); speed_up = 1'b1; t = cyc;
        expect_tick(t + 2,  1'b0, 2'd1);
        expect_tick(t + 10, 1'b1, 2'd1);
        step(1); speed_up = 1'b0;
        step(9);

        // restart on the terminal count at level 0
        speed_clr = 1'b1; step(1); speed_clr = 1'b0;
        step(8);
        restart = 1'b1; step(1); restart = 1'b0;
        chk("restart_tick", int'(tick), 0);
        chk("restart_blink", int'(blink), 1);
        chk("restart_level", int'(level), 0);
        expect_tick(cyc + 10, 1'b0, 2'd0);
        step(10);

        // Build non-zero state, then assert everything together
        speed_up = 1'b1; step(1); speed_up = 1'b0;
        expect_tick(cyc + 7, 1'b1, 2'd1);
        step(7);
        rst = 1'b1; restart = 1'b1; speed_up = 1'b1; speed_clr = 1'b1;
        step(1);
        chk("all_tick", int'(tick), 0);
        chk("all_blink", int'(blink), 0);
        chk("all_level", int'(level), 0);
        chk("all_at_max", int'(at_max), 0);
        rst = 1'b0; restart = 1'b0; speed_up = 1'b0; speed_clr = 1'b0; en = 1'b0;
        step(3);
        chk("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
